// File: rtl/sync_cnt_pkg.sv
// Shared definitions for the loadable counter cells: default width, count type
// and the "about to expire" detect used to predict the terminal count.
package sync_cnt_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int MAX_WIDTH = 32;

    typedef logic [DEF_WIDTH-1:0] cnt_t;

    // Callers zero-extend their count to MAX_WIDTH so any width 2..32 works.
    function automatic logic is_one(input logic [MAX_WIDTH-1:0] v);
        return (v == MAX_WIDTH'(1));
    endfunction

endpackage

// File: rtl/sync_dncnt_cell.sv
// One bit of the down-counter: synchronous clear/load, toggle on decrement
// with borrow-in, and a borrow-out that is high when this and all lower bits are 0.
module sync_dncnt_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic d,
    input  logic dec,
    input  logic borrow_in,
    output logic q,
    output logic qb,
    output logic borrow_out
);

    // The borrow chain is fed a constant 1 at bit 0, so it doubles as the zero detect.
    assign borrow_out = borrow_in & ~q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= 1'b0;
            qb <= 1'b1;
        end else if (clr) begin
            q  <= 1'b0;
            qb <= 1'b1;
        end else if (load) begin
            q  <= d;
            qb <= ~d;
        end else if (dec && borrow_in) begin
            q  <= ~q;
            qb <= q;
        end
    end

endmodule

// File: rtl/sync_dncnt.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload of
// the last loaded value. Holds the reload register, RUN, TC and zero/one detect.
module sync_dncnt
    import sync_cnt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             MasterClock,
    input  logic             RESET,
    input  logic [WIDTH-1:0] D,
    input  logic             LDL,
    input  logic             CLR,
    input  logic             CE,
    input  logic             RLD_EN,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QB,
    output logic             TC,
    output logic             RUN
);

    logic [WIDTH-1:0] rv;
    logic [WIDTH-1:0] cell_d;
    logic [WIDTH-1:0] borrow_in;
    logic [WIDTH-1:0] borrow_out;
    logic             zero;
    logic             one;
    logic             load;
    logic             step;
    logic             reload;
    logic             dec;
    logic             cell_load;

    assign load      = ~LDL & ~CLR;
    assign step      = CE & RUN & LDL & ~CLR;
    assign zero      = borrow_out[WIDTH-1];
    assign one       = is_one(MAX_WIDTH'(Q));
    // A running counter sitting at 0 is only possible in periodic mode.
    assign reload    = step & zero;
    assign dec       = step & ~zero;
    assign cell_load = load | reload;
    assign cell_d    = load ? D : rv;
    assign borrow_in = {borrow_out[WIDTH-2:0], 1'b1};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sync_dncnt_cell u_cell (
            .clk        (MasterClock),
            .rst        (RESET),
            .clr        (CLR),
            .load       (cell_load),
            .d          (cell_d[i]),
            .dec        (dec),
            .borrow_in  (borrow_in[i]),
            .q          (Q[i]),
            .qb         (QB[i]),
            .borrow_out (borrow_out[i])
        );
    end

    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            rv  <= '0;
            RUN <= 1'b0;
            TC  <= 1'b0;
        end else if (CLR) begin
            RUN <= 1'b0;
            TC  <= 1'b0;
        end else if (load) begin
            rv  <= D;
            RUN <= |D;
            TC  <= 1'b0;
        end else if (dec) begin
            TC <= one;
            // RLD_EN matters only on the 1->0 step.
            if (one && !RLD_EN) begin
                RUN <= 1'b0;
            end
        end else begin
            TC <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_dncnt.sv
// Directed bench for sync_dncnt: a table of per-edge input/expected records
// plus hand-written reset sequences.
module tb_sync_dncnt;
    import sync_cnt_pkg::*;

    localparam int WIDTH = 16;

    typedef struct {
        logic ldl;
        logic clr;
        logic ce;
        logic rld;
        cnt_t d;
        cnt_t q;
        logic tc;
        logic run;
    } vec_t;

    logic       clk;
    logic       rst;
    cnt_t       d;
    logic       ldl;
    logic       clr;
    logic       ce;
    logic       rld_en;
    cnt_t       q;
    cnt_t       qb;
    logic       tc;
    logic       run;

    vec_t       vecs[$];
    int         n_cmp;
    int         n_bad;

    sync_dncnt #(.WIDTH(WIDTH)) dut (
        .MasterClock (clk),
        .RESET       (rst),
        .D           (d),
        .LDL         (ldl),
        .CLR         (clr),
        .CE          (ce),
        .RLD_EN      (rld_en),
        .Q           (q),
        .QB          (qb),
        .TC          (tc),
        .RUN         (run)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input cnt_t eq, input logic etc, input logic erun);
        cnt_t eqb;
        eqb = ~eq;
        check({tag, ".Q"},   32'(q),   32'(eq));
        check({tag, ".QB"},  32'(qb),  32'(eqb));
        check({tag, ".TC"},  32'(tc),  32'(etc));
        check({tag, ".RUN"}, 32'(run), 32'(erun));
    endtask

    task automatic add(input logic l, input logic c, input logic e, input logic r, input cnt_t dv,
                       input cnt_t eq, input logic etc, input logic erun);
        vec_t v;
        v.ldl = l; v.clr = c; v.ce = e; v.rld = r; v.d = dv;
        v.q = eq; v.tc = etc; v.run = erun;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ldl = 1'b1; clr = 1'b0; ce = 1'b0; rld_en = 1'b0; d = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle_inputs();
        rst = 1'b1;

        // one-shot load 3
        add(0,0,1,0,16'd3, 16'd3,0,1);
        add(1,0,1,0,16'd0, 16'd2,0,1);
        add(1,0,1,0,16'd0, 16'd1,0,1);
        add(1,0,1,0,16'd0, 16'd0,1,0);
        add(1,0,1,0,16'd0, 16'd0,0,0);
        add(1,0,1,0,16'd0, 16'd0,0,0);
        // periodic load 2
        add(0,0,1,1,16'd2, 16'd2,0,1);
        add(1,0,1,1,16'd0, 16'd1,0,1);
        add(1,0,1,1,16'd0, 16'd0,1,1);
        add(1,0,1,1,16'd0, 16'd2,0,1);
        add(1,0,1,1,16'd0, 16'd1,0,1);
        add(1,0,1,1,16'd0, 16'd0,1,1);
        add(1,0,1,1,16'd0, 16'd2,0,1);
        // load 5 with CE toggling, one-shot
        add(0,0,0,0,16'd5, 16'd5,0,1);
        add(1,0,1,0,16'd0, 16'd4,0,1);
        add(1,0,0,0,16'd0, 16'd4,0,1);
        add(1,0,1,0,16'd0, 16'd3,0,1);
        add(1,0,0,0,16'd0, 16'd3,0,1);
        add(1,0,1,0,16'd0, 16'd2,0,1);
        add(1,0,0,0,16'd0, 16'd2,0,1);
        add(1,0,1,0,16'd0, 16'd1,0,1);
        add(1,0,0,0,16'd0, 16'd1,0,1);
        add(1,0,1,0,16'd0, 16'd0,1,0);
        add(1,0,0,0,16'd0, 16'd0,0,0);
        // same-edge collisions
        add(0,1,0,0,16'd9, 16'd0,0,0);
        add(0,0,0,0,16'd7, 16'd7,0,1);
        add(0,0,1,0,16'd4, 16'd4,0,1);
        add(1,1,1,0,16'd0, 16'd0,0,0);
        add(1,0,1,0,16'd0, 16'd0,0,0);
        // load of zero, both modes
        add(0,0,0,0,16'd0, 16'd0,0,0);
        add(1,0,1,0,16'd0, 16'd0,0,0);
        add(0,0,0,1,16'd0, 16'd0,0,0);
        add(1,0,1,1,16'd0, 16'd0,0,0);
        add(1,0,1,1,16'd0, 16'd0,0,0);
        // all-ones load
        add(0,0,1,0,16'hFFFF, 16'hFFFF,0,1);
        add(1,0,1,0,16'd0,    16'hFFFE,0,1);
        // RLD_EN sampled only at the zero crossing
        add(0,0,1,0,16'd2, 16'd2,0,1);
        add(1,0,1,1,16'd0, 16'd1,0,1);
        add(1,0,1,1,16'd0, 16'd0,1,1);
        add(1,0,1,0,16'd0, 16'd2,0,1);
        add(1,0,1,0,16'd0, 16'd1,0,1);
        add(1,0,1,0,16'd0, 16'd0,1,0);
        // periodic load 1, CE=0 hold clears TC
        add(0,0,1,1,16'd1, 16'd1,0,1);
        add(1,0,1,1,16'd0, 16'd0,1,1);
        add(1,0,0,1,16'd0, 16'd0,0,1);
        add(1,0,1,1,16'd0, 16'd1,0,1);
        add(1,0,1,1,16'd0, 16'd0,1,1);

        #12;
        rst = 1'b0;
        #1;
        check_all("reset", 16'd0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            ldl = vecs[i].ldl; clr = vecs[i].clr; ce = vecs[i].ce;
            rld_en = vecs[i].rld; d = vecs[i].d;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].tc, vecs[i].run);
        end

        // async reset mid-count at Q=9, checked before the next edge
        ldl = 1'b0; d = 16'd12; ce = 1'b1; rld_en = 1'b1;
        tick();
        ldl = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_all("pre_rst", 16'd9, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 16'd0, 1'b0, 1'b0);
        tick();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all($sformatf("post_rst%0d", i), 16'd0, 1'b0, 1'b0);
        end

        idle_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
